image_rom_streamer: RTL and testbench
=====================================

// Module: image_rom_streamer
// PURPOSE
//  Read-side master for the single-port image ROM (1-cycle registered read, rd_en-gated).
//  On start_i, walks NUM_WORDS consecutive addresses from BASE_ADDR and issues ROM reads.
//  Returns the words as a valid/ready pixel stream to the first conv layer, with last_o
//  on the final word. A 2-entry skid FIFO absorbs the in-flight read under backpressure.
// PARAMETERS
//  WIDTH     8                    pixel/ROM word width (bits)
//  DEPTH     784                  ROM depth in words (28x28 image)
//  ADDR_W    $clog2(DEPTH)        ROM address width
//  BASE_ADDR 0                    first ROM address read
//  NUM_WORDS DEPTH                words per frame; legal range 1..DEPTH-BASE_ADDR
// PORTS
//  clk_i        in   1       clock; all logic on posedge
//  rst_i        in   1       synchronous reset, active-high
//  start_i      in   1       1-cycle start pulse; ignored while busy_o=1
//  busy_o       out  1       high from cycle after accepted start until done_o cycle inclusive
//  done_o       out  1       1-cycle pulse after the last_o word handshakes
//  rom_rd_en_o  out  1       ROM read enable
//  rom_addr_o   out  ADDR_W  ROM address; valid when rom_rd_en_o=1
//  rom_data_i   in   WIDTH   ROM read data; valid 1 cycle after rom_rd_en_o
//  m_valid_o    out  1       stream data valid
//  m_ready_i    in   1       stream consumer ready
//  m_data_o     out  WIDTH   pixel word = FIFO head
//  m_last_o     out  1       high with the NUM_WORDS-th word of the frame
// BEHAVIOUR
//  Reset: busy_o=0, done_o=0, rom_rd_en_o=0, rom_addr_o=0, m_valid_o=0, m_last_o=0,
//   FIFO emptied, in-flight flag cleared, FSM=IDLE. Reset mid-frame aborts the frame
//   with no further valid words or done pulse; the read returning after reset is dropped.
//  FSM: IDLE -start_i-> FETCH; FETCH -last address issued-> DRAIN;
//   DRAIN -last word handshaken-> DONE; DONE -> IDLE (1 cycle; done_o=1 here).
//  Read issue (FETCH only): rom_rd_en_o=1 when fifo_cnt + inflight - pop < 2,
//   where pop = m_valid_o & m_ready_i. rom_addr_o = BASE_ADDR + issue_cnt, and
//   issue_cnt increments per issued read; rom_addr_o is driven combinationally from it.
//   Never issue more than NUM_WORDS reads per frame.
//  Return: inflight <= rom_rd_en_o; when inflight=1, rom_data_i is pushed to FIFO that
//   cycle. Same-cycle push and pop keeps the count. The FIFO never overflows given the
//   issue rule; overflow is an assertion failure.
//  Output: m_valid_o = (fifo_cnt != 0); m_data_o = head. m_data_o/m_last_o are held stable
//   while m_valid_o=1 and m_ready_i=0. m_last_o = m_valid_o & (out_cnt == NUM_WORDS-1).
//  Throughput: with m_ready_i held at 1, one word per cycle. The first m_valid_o comes 3
//   cycles after start_i: start, issue, return/push, then valid.
//  Counters are ADDR_W+1 bits wide and do not wrap within a frame. For NUM_WORDS=1, the
//   first word also carries m_last_o.
//  start_i in the done_o cycle is ignored. A new start_i is accepted from the next
//   (IDLE) cycle.
// TESTING
//  1 reset, NUM_WORDS=4, ROM[i]=i+1, m_ready_i=1, start_i @c0 -> rom_rd_en_o c1..c4 addr 0..3;
//    m_data_o 1,2,3,4 on c3..c6, m_last_o @c6, done_o @c7, busy_o c1..c7.
//  2 same, m_ready_i=0 c3..c8 -> exactly 2 reads issued before stall (fifo full, 0 inflight);
//    m_data_o=1 held stable; all 4 words delivered in order after ready rises.
//  3 random m_ready_i (50%), NUM_WORDS=784 -> 784 words in address order, one m_last_o,
//    one done_o; FIFO never exceeds 2.
//  4 start_i pulsed again at c2 and at the done_o cycle -> ignored; no extra reads.
//  5 rst_i asserted mid-frame with a read inflight -> next cycle m_valid_o=0, rom_rd_en_o=0,
//    no done_o; subsequent start_i streams a full correct frame from BASE_ADDR.
//  6 BASE_ADDR=780, NUM_WORDS=4 -> addresses 780..783; m_last_o on word from 783.

Source files
------------

// File: rtl/image_rom_streamer_if.sv
// Pixel stream bundle: valid/ready handshake carrying one ROM word plus end-of-frame marker.
interface image_rom_streamer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/image_rom_streamer.sv
// Streams NUM_WORDS consecutive image ROM words from BASE_ADDR as a valid/ready pixel stream,
// using a 2-entry skid FIFO to absorb the read already in flight when the consumer stalls.
module image_rom_streamer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 784,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_WORDS = DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_rd_en_o,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [WIDTH-1:0]      rom_data_i,
  image_rom_streamer_if.master  m
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  localparam logic [ADDR_W:0] NumWords = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W:0] LastIdx  = (ADDR_W+1)'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W:0]   issue_cnt_q, out_cnt_q;
  logic              inflight_q;
  logic [WIDTH-1:0]  fifo_mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic              valid, last, push, pop, rd_en;
  logic [2:0]        occ;

  always_comb begin
    valid = (fifo_cnt_q != 2'd0);
    last  = valid && (out_cnt_q == LastIdx);
    pop   = valid && m.ready;
    push  = inflight_q;
    // Slots that will still be taken next cycle if nothing new is issued now.
    occ   = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    rd_en = (state_q == StFetch) && (issue_cnt_q < NumWords) && (occ < 3'd2);
  end

  assign rom_rd_en_o = rd_en;
  assign rom_addr_o  = ADDR_W'(BASE_ADDR) + issue_cnt_q[ADDR_W-1:0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign m.valid     = valid;
  assign m.data      = fifo_mem_q[rd_ptr_q];
  assign m.last      = last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      if (rd_en) issue_cnt_q <= issue_cnt_q + CntOne;
      if (push)  wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + CntOne;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: ;
      endcase

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StFetch;
            busy_q      <= 1'b1;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
          end
        end
        StFetch: if (rd_en && (issue_cnt_q == LastIdx)) state_q <= StDrain;
        StDrain: begin
          if (pop && last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rom_data_i;
  end

  // The issue rule guarantees a free slot for every returning read.
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == 2'd2)));

endmodule

// File: tb/tb_image_rom_streamer.sv
// Scoreboard bench for image_rom_streamer: three configurations, expected reads and words
// queued at start, compared as the DUT issues reads and hands over words.
module tb_image_rom_streamer;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 784;
  localparam int unsigned AW = $clog2(D);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  always #5 clk = ~clk;

  logic          busy_a, done_a, rd_a, busy_b, done_b, rd_b, busy_c, done_c, rd_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [W-1:0]  rom_a, rom_b, rom_c;

  image_rom_streamer_if #(.WIDTH(W)) if_a ();
  image_rom_streamer_if #(.WIDTH(W)) if_b ();
  image_rom_streamer_if #(.WIDTH(W)) if_c ();
  assign if_a.ready = ready;
  assign if_b.ready = ready;
  assign if_c.ready = ready;

  image_rom_streamer #(.WIDTH(W), .DEPTH(D), .BASE_ADDR(0), .NUM_WORDS(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .rom_rd_en_o(rd_a), .rom_addr_o(addr_a), .rom_data_i(rom_a), .m(if_a));
  image_rom_streamer #(.WIDTH(W), .DEPTH(D), .BASE_ADDR(0), .NUM_WORDS(784)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .rom_rd_en_o(rd_b), .rom_addr_o(addr_b), .rom_data_i(rom_b), .m(if_b));
  image_rom_streamer #(.WIDTH(W), .DEPTH(D), .BASE_ADDR(780), .NUM_WORDS(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .busy_o(busy_c), .done_o(done_c),
    .rom_rd_en_o(rd_c), .rom_addr_o(addr_c), .rom_data_i(rom_c), .m(if_c));

  // ROM model: ROM[i] = i+1 (mod 256), 1-cycle registered read
  always @(posedge clk) begin
    if (rd_a) rom_a <= W'(32'(addr_a) + 1);
    if (rd_b) rom_b <= W'(32'(addr_b) + 1);
    if (rd_c) rom_c <= W'(32'(addr_c) + 1);
  end

  int sel = 0;
  logic          o_busy, o_done, o_rd, o_valid, o_last;
  logic [AW-1:0] o_addr;
  logic [W-1:0]  o_data;
  always_comb begin
    o_busy = busy_a; o_done = done_a; o_rd = rd_a; o_addr = addr_a;
    o_valid = if_a.valid; o_data = if_a.data; o_last = if_a.last;
    case (sel)
      1: begin
        o_busy = busy_b; o_done = done_b; o_rd = rd_b; o_addr = addr_b;
        o_valid = if_b.valid; o_data = if_b.data; o_last = if_b.last;
      end
      2: begin
        o_busy = busy_c; o_done = done_c; o_rd = rd_c; o_addr = addr_c;
        o_valid = if_c.valid; o_data = if_c.data; o_last = if_c.last;
      end
      default: ;
    endcase
  end

  int n_vec = 0, n_err = 0;
  int unsigned addr_q[$];
  logic [8:0]  data_q[$];
  int n_rd, n_pop, n_last, n_done, max_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_sb();
    addr_q.delete();
    data_q.delete();
    n_rd = 0; n_pop = 0; n_last = 0; n_done = 0; max_out = 0;
  endtask

  task automatic push_frame(input int unsigned base, input int unsigned n);
    clear_sb();
    for (int unsigned i = 0; i < n; i++) begin
      addr_q.push_back(base + i);
      data_q.push_back({(i == n - 1), W'(base + i + 1)});
    end
  endtask

  task automatic set_start(input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Drives start during c0; returns at posedge+1 of c1
  task automatic pulse_start();
    @(posedge clk); #1 set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();
  endtask

  task automatic run_until_done(input string tag, input int budget, input bit rnd);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      seen = o_done;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  task automatic frame_end_checks(input string tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, addr_q.size() + data_q.size(), 0);
    check({tag, "_last_cnt"}, n_last, 1);
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_outstanding_gt2"}, 32'(max_out > 2), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rd) begin
        n_rd++;
        if (addr_q.size() == 0) check("extra_read", 32'(o_addr), 32'hffff_ffff);
        else                    check("rd_addr", 32'(o_addr), addr_q.pop_front());
      end
      if (o_valid && ready) begin
        n_pop++;
        if (o_last) n_last++;
        if (data_q.size() == 0) check("extra_word", 32'({o_last, o_data}), 32'hffff_ffff);
        else                    check("word", 32'({o_last, o_data}), 32'(data_q.pop_front()));
      end
      if (o_done) n_done++;
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: basic frame timing, NUM_WORDS=4
    sel = 0;
    do_reset();
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_rd_en", 32'(o_rd), 0);
    check("rst_addr", 32'(o_addr), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_last", 32'(o_last), 0);
    push_frame(0, 4);
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", k), 32'(o_busy), 32'(k <= 7));
      check($sformatf("t1_done_c%0d", k), 32'(o_done), 32'(k == 7));
      check($sformatf("t1_rd_en_c%0d", k), 32'(o_rd), 32'(k <= 4));
      check($sformatf("t1_valid_c%0d", k), 32'(o_valid), 32'(k >= 3 && k <= 6));
      @(posedge clk); #1;
    end
    frame_end_checks("t1");

    // 2: backpressure c3..c8
    push_frame(0, 4);
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      ready = !(k >= 3 && k <= 8);
      @(negedge clk);
      if (k >= 3 && k <= 8) begin
        check($sformatf("t2_valid_c%0d", k), 32'(o_valid), 1);
        check($sformatf("t2_data_c%0d", k), 32'(o_data), 1);
      end
      if (k == 8) check("t2_reads_before_stall", n_rd, 2);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    frame_end_checks("t2");

    // 3: full 784-word frame under random backpressure
    sel = 1;
    push_frame(0, 784);
    pulse_start();
    run_until_done("t3", 8000, 1'b1);
    frame_end_checks("t3");

    // 4: start pulses while busy and in the done cycle are ignored
    sel = 0;
    push_frame(0, 4);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      set_start(k == 2 || k == 7);
      @(negedge clk);
      if (k == 7) check("t4_done_c7", 32'(o_done), 1);
      if (k >= 8) begin
        check($sformatf("t4_busy_c%0d", k), 32'(o_busy), 0);
        check($sformatf("t4_rd_en_c%0d", k), 32'(o_rd), 0);
      end
      @(posedge clk); #1;
    end
    set_start(1'b0);
    frame_end_checks("t4");

    // 5: reset with a read in flight aborts the frame
    push_frame(0, 4);
    pulse_start();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(o_valid), 0);
    check("t5_rd_en_after_rst", 32'(o_rd), 0);
    check("t5_busy_after_rst", 32'(o_busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_done", n_done, 0);
    check("t5_no_words", n_pop, 0);
    push_frame(0, 4);
    pulse_start();
    run_until_done("t5", 100, 1'b0);
    frame_end_checks("t5");

    // 6: BASE_ADDR=780, NUM_WORDS=4
    sel = 2;
    push_frame(780, 4);
    pulse_start();
    run_until_done("t6", 100, 1'b1);
    frame_end_checks("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
